cordic_vector_iter: RTL and testbench

CORDIC_VECTOR_ITER -- requirements
Module: cordic_vector_iter

---
 rtl/cordic_vector_iter.sv | 155 +++++++++++++++
 tb/tb_cordic_vector_iter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC: magnitude and atan2 of (Xin, Yin), one micro-rotation per clock.
// Optional CORDIC_GAIN_COMP_EN scales the final magnitude by ~0.6074 to remove the CORDIC gain.
module cordic_vector_iter #(
    parameter int ITER = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [17:0] Xin,
    input  logic signed [17:0] Yin,
    output logic signed [17:0] Mag,
    output logic signed [17:0] Angle,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    state_t             state_q, state_d;
    logic signed [19:0] x_q, x_d, y_q, y_d;
    logic signed [17:0] z_q, z_d;
    logic [4:0]         i_q, i_d;
    logic               zero_q, zero_d;
    logic signed [17:0] mag_q, mag_d, ang_q, ang_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic signed [19:0] xe, ye, x_sh, y_sh, mag_raw;

    function automatic logic signed [17:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = 18'sd32768;
            5'd1:    atan_lut = 18'sd19344;
            5'd2:    atan_lut = 18'sd10221;
            5'd3:    atan_lut = 18'sd5188;
            5'd4:    atan_lut = 18'sd2604;
            5'd5:    atan_lut = 18'sd1303;
            5'd6:    atan_lut = 18'sd652;
            5'd7:    atan_lut = 18'sd326;
            5'd8:    atan_lut = 18'sd163;
            5'd9:    atan_lut = 18'sd81;
            5'd10:   atan_lut = 18'sd41;
            5'd11:   atan_lut = 18'sd20;
            5'd12:   atan_lut = 18'sd10;
            5'd13:   atan_lut = 18'sd5;
            5'd14:   atan_lut = 18'sd3;
            5'd15:   atan_lut = 18'sd1;
            default: atan_lut = 18'sd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        xe      = {{2{Xin[17]}}, Xin};
        ye      = {{2{Yin[17]}}, Yin};
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
`ifdef CORDIC_GAIN_COMP_EN
        mag_raw = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
`else
        mag_raw = x_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = ROT;
                    busy_d  = 1'b1;
                    i_d     = 5'd0;
                    zero_d  = (Xin == 18'sd0) && (Yin == 18'sd0);
                    // Left half-plane operands are pre-rotated by +/-90 deg into the right half
                    if (!Xin[17]) begin
                        x_d = xe;
                        y_d = ye;
                        z_d = 18'sd0;
                    end else if (!Yin[17]) begin
                        x_d = ye;
                        y_d = -xe;
                        z_d = 18'sd65536;
                    end else begin
                        x_d = -ye;
                        y_d = xe;
                        z_d = -18'sd65536;
                    end
                end
            end
            ROT: begin
                if (i_q == 5'(ITER)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ang_d   = zero_q ? 18'sd0 : z_q;
                    if (mag_raw > 20'sd131071)
                        mag_d = 18'sd131071;
                    else if (mag_raw < -20'sd131072)
                        mag_d = -18'sd131072;
                    else
                        mag_d = mag_raw[17:0];
                end else begin
                    i_d = i_q + 5'd1;
                    if (!y_q[19]) begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_lut(i_q);
                    end else begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_lut(i_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Mag   = mag_q;
    assign Angle = ang_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Bench for cordic_vector_iter: cycle model of busy/done timing with an integer CORDIC
// reference, real-valued atan2/hypot sanity checks and hand-computed vectors.
module tb_cordic_vector_iter;

    localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int MAG_X  = 10003;
    localparam int MAG_XY = 14146;
    localparam real KC    = 0.607421875;
`else
    localparam int MAG_X  = 16468;
    localparam int MAG_XY = 23289;
    localparam real KC    = 1.0;
`endif
    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [17:0] Xin = '0;
    logic signed [17:0] Yin = '0;
    logic signed [17:0] Mag, Angle;
    logic               busy, done;

    cordic_vector_iter #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .Xin(Xin), .Yin(Yin),
        .Mag(Mag), .Angle(Angle), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  A[16];
    real gain = 1.0;

    int  left = 0;
    int  e_done = 0;
    int  e_mag = 0;
    int  e_ang = 0;
    int  op_x = 0;
    int  op_y = 0;
    int  done_cnt = 0;

    function automatic int wrap18(input int v);
        int r;
        r = v & 32'h3FFFF;
        if (r >= 131072) r = r - 262144;
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Integer reference of the vectoring algorithm on plain ints
    function automatic void model(input int xi, input int yi,
                                  output int mag, output int ang);
        int x, y, z, xo, yo, m;
        if (xi == 0 && yi == 0) begin
            mag = 0;
            ang = 0;
            return;
        end
        if (xi >= 0) begin x = xi; y = yi; z = 0; end
        else if (yi >= 0) begin x = yi; y = -xi; z = 65536; end
        else begin x = -yi; y = xi; z = -65536; end
        for (int i = 0; i < ITER; i++) begin
            xo = x;
            yo = y;
            if (yo >= 0) begin
                x = xo + (yo >>> i); y = yo - (xo >>> i); z = z + A[i];
            end else begin
                x = xo - (yo >>> i); y = yo + (xo >>> i); z = z - A[i];
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        m = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`else
        m = x;
`endif
        if (m > 131071) m = 131071;
        mag = m;
        ang = wrap18(z);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp,
                            input int tol, input bit circ);
        int d;
        d = act - exp;
        if (circ) d = wrap18(d);
        checks++;
        if (iabs(d) > tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, exp, tol);
        end
    endtask

    // Floating-point atan2/hypot reference for the result currently on the outputs
    task automatic chk_ref(input string name, input int x, input int y);
        real a, m;
        int  mi;
        a = $atan2(real'(y), real'(x)) * 131072.0 / PI;
        m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * gain * KC;
        mi = $rtoi($floor(m + 0.5));
        if (mi > 131071) mi = 131071;
        chk_near({name, "_ref_ang"}, Angle, $rtoi($floor(a + 0.5)), 6, 1'b1);
        chk_near({name, "_ref_mag"}, Mag, mi, 16, 1'b0);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left = 0; e_done = 0; e_mag = 0; e_ang = 0;
        end else if (start && left == 0) begin
            op_x = Xin; op_y = Yin; left = ITER + 1; e_done = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                e_done = 1;
                model(op_x, op_y, e_mag, e_ang);
            end
        end else begin
            e_done = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), (left > 0) ? 1 : 0);
        chk("done", int'(done), e_done);
        chk("mag", int'(Mag), e_mag);
        chk("angle", int'(Angle), e_ang);
        if (done) done_cnt++;
    end

    task automatic launch(input int x, input int y);
        Xin = 18'(x);
        Yin = 18'(y);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run(input string name, input int x, input int y);
        int n;
        launch(x, y);
        wait_done(n);
        chk({name, "_latency"}, n, ITER + 1);
        chk_ref(name, x, y);
    endtask

    initial begin
        int m, a, n, d0;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int m, a, n, d0;
        for (int i = 0; i < 16; i++)
            A[i] = $rtoi($floor($atan(2.0 ** (-i)) * 131072.0 / PI + 0.5));
        for (int i = 0; i < ITER; i++)
            gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mag", int'(Mag), 0);
        chk("rst_angle", int'(Angle), 0);
        rst = 1'b0;

        chk("A0", A[0], 32768);
        chk("A1", A[1], 19344);
        chk("A2", A[2], 10221);
        chk("A3", A[3], 5188);
        model(10000, 0, m, a);
        chk_near("model_x_mag", m, MAG_X, 8, 1'b0);
        chk_near("model_x_ang", a, 0, 4, 1'b1);
        model(10000, 10000, m, a);
        chk_near("model_xy_mag", m, MAG_XY, 8, 1'b0);
        chk_near("model_xy_ang", a, 32768, 4, 1'b1);

        @(posedge clk);
        #1;
        run("x_axis", 10000, 0);
        chk_near("x_axis_ang", Angle, 0, 4, 1'b1);
        chk_near("x_axis_mag", Mag, MAG_X, 8, 1'b0);
        run("diag", 10000, 10000);
        chk_near("diag_ang", Angle, 32768, 4, 1'b1);
        chk_near("diag_mag", Mag, MAG_XY, 8, 1'b0);
        run("neg_x", -10000, 0);
        chk_near("neg_x_ang", Angle, -131072, 4, 1'b1);
        run("neg_y", 0, -10000);
        chk_near("neg_y_ang", Angle, -65536, 4, 1'b1);
        run("zero", 0, 0);
        chk("zero_mag", int'(Mag), 0);
        chk("zero_ang", int'(Angle), 0);

        // back-to-back: start while done is high
        run("b2b", -30000, -20000);
        run("sat", 65535, 65535);
        run("q2", -5000, 12345);

        repeat (3) @(posedge clk);
        #1;
        d0 = done_cnt;
        launch(1234, -4321);
        repeat (4) @(posedge clk);
        #1;
        Xin = 18'sd999;
        Yin = 18'sd777;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        chk("ignore_latency", (n < 0) ? n : n + 5, ITER + 1);
        chk_ref("ignore", 1234, -4321);
        repeat (30) @(posedge clk);
        #1;
        chk("ignore_done_count", done_cnt - d0, 1);

        launch(20000, 7000);
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_mag", int'(Mag), 0);
        chk("abort_angle", int'(Angle), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        run("after_rst", 20000, 7000);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
